// File: rtl/cube_colors_pkg.sv
// Colour codes and FSM state types shared by the cube-state reader blocks.
package cube_colors_pkg;

    typedef logic [2:0] color_t;

    localparam color_t W       = 3'd0;
    localparam color_t O       = 3'd1;
    localparam color_t G       = 3'd2;
    localparam color_t R       = 3'd3;
    localparam color_t B       = 3'd4;
    localparam color_t Y       = 3'd5;
    localparam color_t INVALID = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2
    } filt_state_t;

    function automatic logic pair_ok(input color_t a, input color_t b);
        return (a != INVALID) && (b != INVALID);
    endfunction

endpackage

// File: rtl/color_classify.sv
// Combinational RGB-to-sticker-colour classifier; first matching rule wins.
module color_classify
    import cube_colors_pkg::*;
(
    input  logic [23:0] rgb_i,
    input  logic [7:0]  hi_i,
    input  logic [7:0]  lo_i,
    output color_t      color_o
);

    logic [7:0] r_ch;
    logic [7:0] g_ch;
    logic [7:0] b_ch;
    logic       r_hi;
    logic       g_hi;
    logic       b_hi;
    logic       g_lo;

    assign r_ch = rgb_i[23:16];
    assign g_ch = rgb_i[15:8];
    assign b_ch = rgb_i[7:0];

    assign r_hi = (r_ch >= hi_i);
    assign g_hi = (g_ch >= hi_i);
    assign b_hi = (b_ch >= hi_i);
    assign g_lo = (g_ch >= lo_i);

    always_comb begin
        color_o = INVALID;
        if (r_hi && g_hi && b_hi) begin
            color_o = W;
        end else if (r_hi && g_hi) begin
            color_o = Y;
        end else if (r_hi && g_lo) begin
            color_o = O;
        end else if (r_hi) begin
            color_o = R;
        end else if (g_hi) begin
            color_o = G;
        end else if (b_hi) begin
            color_o = B;
        end
    end

endmodule

// File: rtl/color_sensor_filter.sv
// Settles after each move, then releases an edge/corner colour pair once it
// has been read identically STABLE_COUNT times in a row; flags a fault on timeout.
module color_sensor_filter
    import cube_colors_pkg::*;
#(
    parameter int         SETTLE_CYCLES   = 50000,
    parameter int         STABLE_COUNT    = 4,
    parameter int         TIMEOUT_SAMPLES = 64,
    parameter logic [7:0] HI              = 8'd160,
    parameter logic [7:0] LO              = 8'd80
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        motors_done,
    input  logic        sample_valid,
    input  logic [23:0] edge_rgb,
    input  logic [23:0] corner_rgb,
    output color_t      edge_color_sensor,
    output color_t      corner_color_sensor,
    output logic        color_sensor_stable,
    output logic        sensor_fault
);

    localparam int              SW          = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SW-1:0]   SETTLE_LOAD = SW'(SETTLE_CYCLES);
    localparam logic [SW-1:0]   SETTLE_LAST = SW'(1);
    localparam logic [3:0]      STABLE_LIM  = 4'(STABLE_COUNT);
    localparam logic [7:0]      TIMEOUT_LIM = 8'(TIMEOUT_SAMPLES);

    filt_state_t   state_q;
    logic [SW-1:0] settle_cnt_q;
    logic [3:0]    match_cnt_q;
    logic [3:0]    match_cnt_d;
    logic [7:0]    sample_cnt_q;
    logic [7:0]    sample_cnt_d;
    color_t        prev_edge_q;
    color_t        prev_corner_q;
    color_t        edge_col_q;
    color_t        corner_col_q;
    logic          stable_q;
    logic          fault_q;

    color_t        edge_class;
    color_t        corner_class;
    logic          same_as_prev;
    logic          release_hit;
    logic          timeout_hit;

    color_classify u_edge_classify (
        .rgb_i   (edge_rgb),
        .hi_i    (HI),
        .lo_i    (LO),
        .color_o (edge_class)
    );

    color_classify u_corner_classify (
        .rgb_i   (corner_rgb),
        .hi_i    (HI),
        .lo_i    (LO),
        .color_o (corner_class)
    );

    assign same_as_prev = (edge_class == prev_edge_q) && (corner_class == prev_corner_q);

    always_comb begin
        match_cnt_d = 4'd1;
        if (!pair_ok(edge_class, corner_class)) begin
            match_cnt_d = 4'd0;
        end else if (same_as_prev) begin
            match_cnt_d = match_cnt_q + 4'd1;
        end
    end

    assign sample_cnt_d = sample_cnt_q + 8'd1;
    // Release is checked first so a sample that both releases and times out is a release.
    assign release_hit  = (match_cnt_d == STABLE_LIM);
    assign timeout_hit  = (sample_cnt_d == TIMEOUT_LIM);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            settle_cnt_q  <= '0;
            match_cnt_q   <= '0;
            sample_cnt_q  <= '0;
            prev_edge_q   <= INVALID;
            prev_corner_q <= INVALID;
            edge_col_q    <= W;
            corner_col_q  <= W;
            stable_q      <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            stable_q <= 1'b0;
            // A new move always restarts settling, whatever the FSM was doing.
            if (motors_done) begin
                state_q      <= ST_SETTLE;
                settle_cnt_q <= SETTLE_LOAD;
                match_cnt_q  <= '0;
                sample_cnt_q <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q <= ST_IDLE;
                    end
                    ST_SETTLE: begin
                        if (settle_cnt_q == SETTLE_LAST) begin
                            state_q       <= ST_SAMPLE;
                            settle_cnt_q  <= '0;
                            match_cnt_q   <= '0;
                            sample_cnt_q  <= '0;
                            prev_edge_q   <= INVALID;
                            prev_corner_q <= INVALID;
                        end else begin
                            settle_cnt_q <= settle_cnt_q - SETTLE_LAST;
                        end
                    end
                    ST_SAMPLE: begin
                        if (sample_valid) begin
                            sample_cnt_q  <= sample_cnt_d;
                            match_cnt_q   <= match_cnt_d;
                            prev_edge_q   <= edge_class;
                            prev_corner_q <= corner_class;
                            if (release_hit) begin
                                edge_col_q   <= edge_class;
                                corner_col_q <= corner_class;
                                stable_q     <= 1'b1;
                                state_q      <= ST_IDLE;
                            end else if (timeout_hit) begin
                                fault_q <= 1'b1;
                                state_q <= ST_IDLE;
                            end
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign edge_color_sensor   = edge_col_q;
    assign corner_color_sensor = corner_col_q;
    assign color_sensor_stable = stable_q;
    assign sensor_fault        = fault_q;

endmodule

// File: tb/tb_color_sensor_filter.sv
// Directed bench for color_sensor_filter with a reduced settle time of 8 cycles.
module tb_color_sensor_filter;

    logic        clock;
    logic        reset_n;
    logic        motors_done;
    logic        sample_valid;
    logic [23:0] edge_rgb;
    logic [23:0] corner_rgb;
    logic [2:0]  edge_color_sensor;
    logic [2:0]  corner_color_sensor;
    logic        color_sensor_stable;
    logic        sensor_fault;

    int errors = 0;
    int checks = 0;

    color_sensor_filter #(
        .SETTLE_CYCLES   (8),
        .STABLE_COUNT    (4),
        .TIMEOUT_SAMPLES (64),
        .HI              (8'd160),
        .LO              (8'd80)
    ) dut (
        .clock               (clock),
        .reset_n             (reset_n),
        .motors_done         (motors_done),
        .sample_valid        (sample_valid),
        .edge_rgb            (edge_rgb),
        .corner_rgb          (corner_rgb),
        .edge_color_sensor   (edge_color_sensor),
        .corner_color_sensor (corner_color_sensor),
        .color_sensor_stable (color_sensor_stable),
        .sensor_fault        (sensor_fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [23:0] e_rgb;
        logic [23:0] c_rgb;
        logic [2:0]  exp_e;
        logic [2:0]  exp_c;
        bit          rel;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // motors_done is high across exactly one rising edge (edge t); returns at the negedge after t.
    task automatic pulse_md();
        @(negedge clock);
        motors_done = 1'b1;
        @(negedge clock);
        motors_done = 1'b0;
    endtask

    // Holds one pair with sample_valid high; reports the first cycle (after edge t) with stable high.
    task automatic run_window(input logic [23:0] e, input logic [23:0] c, input int budget,
                              output int first_n, output int stable_cycles);
        pulse_md();
        edge_rgb      = e;
        corner_rgb    = c;
        sample_valid  = 1'b1;
        first_n       = 0;
        stable_cycles = 0;
        for (int n = 1; n <= budget; n++) begin
            @(negedge clock);
            if (color_sensor_stable) begin
                stable_cycles++;
                if (first_n == 0) first_n = n;
            end
        end
        sample_valid = 1'b0;
    endtask

    initial begin
        int fn;
        int sc;
        int fault_n;
        logic [2:0] exp_e;
        logic [2:0] exp_c;

        vecs[0] = '{24'hF0F0F0, 24'h2020F0, 3'd0, 3'd4, 1'b1};
        vecs[1] = '{24'hF0F020, 24'hF06020, 3'd5, 3'd1, 1'b1};
        vecs[2] = '{24'hF02020, 24'h20F020, 3'd3, 3'd2, 1'b1};
        vecs[3] = '{24'hA0A0A0, 24'hA05000, 3'd0, 3'd1, 1'b1};
        vecs[4] = '{24'hA04F00, 24'h00A000, 3'd3, 3'd2, 1'b1};
        vecs[5] = '{24'h9F9F9F, 24'h0000A0, 3'd7, 3'd4, 1'b0};
        vecs[6] = '{24'h202020, 24'hF0F020, 3'd7, 3'd5, 1'b0};
        vecs[7] = '{24'hF0F020, 24'h9FA0F0, 3'd5, 3'd2, 1'b1};

        reset_n      = 1'b1;
        motors_done  = 1'b0;
        sample_valid = 1'b0;
        edge_rgb     = '0;
        corner_rgb   = '0;
        #2 reset_n = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        check("reset_edge",   edge_color_sensor,   0);
        check("reset_corner", corner_color_sensor, 0);
        check("reset_stable", color_sensor_stable, 0);
        check("reset_fault",  sensor_fault,        0);

        exp_e = 3'd0;
        exp_c = 3'd0;
        for (int i = 0; i < 8; i++) begin
            run_window(vecs[i].e_rgb, vecs[i].c_rgb, 20, fn, sc);
            if (vecs[i].rel) begin
                exp_e = vecs[i].exp_e;
                exp_c = vecs[i].exp_c;
            end
            check($sformatf("vec%0d_latency", i), fn, vecs[i].rel ? 12 : 0);
            check($sformatf("vec%0d_pulses", i),  sc, vecs[i].rel ? 1 : 0);
            check($sformatf("vec%0d_edge", i),    edge_color_sensor,   exp_e);
            check($sformatf("vec%0d_corner", i),  corner_color_sensor, exp_c);
            check($sformatf("vec%0d_fault", i),   sensor_fault, 0);
        end

        // Sparse: only every 5th cycle carries a sample.
        pulse_md();
        edge_rgb   = 24'h2020F0;
        corner_rgb = 24'hF0F020;
        fn = 0;
        sc = 0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clock);
            if (color_sensor_stable) begin
                sc++;
                if (fn == 0) fn = n;
            end
            sample_valid = ((n % 5) == 4);
        end
        sample_valid = 1'b0;
        check("sparse_latency", fn, 25);
        check("sparse_pulses",  sc, 1);
        check("sparse_edge",    edge_color_sensor,   4);
        check("sparse_corner",  corner_color_sensor, 5);

        // Restart: motors_done coincides with the 3rd matching sample.
        pulse_md();
        edge_rgb     = 24'h20F020;
        corner_rgb   = 24'h20F020;
        sample_valid = 1'b1;
        fn = 0;
        sc = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clock);
            if (color_sensor_stable) begin
                sc++;
                if (fn == 0) fn = n;
            end
            motors_done = (n == 10);
        end
        sample_valid = 1'b0;
        check("restart_latency", fn, 23);
        check("restart_pulses",  sc, 1);
        check("restart_edge",    edge_color_sensor,   2);
        check("restart_corner",  corner_color_sensor, 2);

        // Flicker: corner alternates R/O every cycle, so no pair ever repeats.
        pulse_md();
        edge_rgb     = 24'hF0F020;
        corner_rgb   = 24'hF02020;
        sample_valid = 1'b1;
        sc      = 0;
        fault_n = 0;
        for (int n = 1; n <= 80; n++) begin
            @(negedge clock);
            if (color_sensor_stable) sc++;
            if (sensor_fault && fault_n == 0) fault_n = n;
            corner_rgb = (n % 2 == 1) ? 24'hF06020 : 24'hF02020;
        end
        sample_valid = 1'b0;
        check("flicker_pulses",  sc, 0);
        check("flicker_fault_n", fault_n, 72);
        check("flicker_edge",    edge_color_sensor,   2);
        check("flicker_corner",  corner_color_sensor, 2);

        // Reset in the middle of a matching run with the fault flag set.
        pulse_md();
        edge_rgb     = 24'h20F020;
        corner_rgb   = 24'h20F020;
        sample_valid = 1'b1;
        for (int n = 1; n <= 10; n++) @(negedge clock);
        check("pre_reset_fault", sensor_fault, 1);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_edge",   edge_color_sensor,   0);
        check("async_rst_corner", corner_color_sensor, 0);
        check("async_rst_stable", color_sensor_stable, 0);
        check("async_rst_fault",  sensor_fault,        0);
        @(negedge clock);
        reset_n = 1'b1;
        sc = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clock);
            if (color_sensor_stable) sc++;
        end
        sample_valid = 1'b0;
        check("post_rst_ignored", sc, 0);
        check("post_rst_edge",    edge_color_sensor, 0);
        run_window(24'hF0F020, 24'hF02020, 20, fn, sc);
        check("post_rst_latency", fn, 12);
        check("post_rst_edge2",   edge_color_sensor,   5);
        check("post_rst_corner2", corner_color_sensor, 3);
        check("post_rst_fault",   sensor_fault, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
